mdu_hilo: RTL and testbench

//  Parametrised multiply/divide unit owning the HI/LO register pair; it is the

---
 rtl/mdu_hilo.sv | 229 ++++++++++++++++++++++
 tb/tb_mdu_hilo.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mdu_hilo.sv
// mdu_hilo -- multiply/divide unit that owns the HI/LO register pair.
//
// Runs MULT/MULTU/DIV/DIVU either iteratively (one bit per cycle) or, for
// multiplies with FAST_MUL=1, in a single cycle. MTHI/MTLO copy 'a' into
// HI or LO. The controller stalls on busy and reads hi/lo for MFHI/MFLO.
//
// Parameters
//   WIDTH        operand and HI/LO width (>=4, even)
//   FAST_MUL     1: one-cycle registered multiply, 0: shift-add over WIDTH cycles
//
// Ports
//   clk          rising-edge clock
//   rst          asynchronous reset, active high
//   start        request, accepted only while busy=0 and flush=0
//   op           0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6/7 ignored
//   a, b         rs / rt operands
//   flush        aborts an in-flight multiply/divide without touching hi/lo
//   busy         an iterative op is in flight
//   done         one-cycle pulse, hi/lo already hold the result
//   div_by_zero  pulses with done when a divide had b==0
//   hi, lo       HI and LO registers
module mdu_hilo #(
    parameter int WIDTH    = 32,
    parameter bit FAST_MUL = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH);

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    typedef enum logic [2:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_FIX,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [CW-1:0]      step_q, step_d;
    logic               isDiv_q, isDiv_d;
    logic               negLo_q, negLo_d;
    logic               negHi_q, negHi_d;
    logic               dbz_q, dbz_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;

    logic               signedOp, aNeg, bNeg, accept, lastStep;
    logic [WIDTH-1:0]   aMag, bMag;
    logic [2*WIDTH-1:0] aExt, bExt, fastProd;
    logic [WIDTH:0]     mulSum;
    logic [2*WIDTH-1:0] mulNext;
    logic [WIDTH:0]     remShift;
    logic               divFits;
    logic [2*WIDTH-1:0] divNext;

    // Signed ops work on magnitudes; the result signs are applied in FIX.
    assign signedOp = (op == OP_MULT) || (op == OP_DIV);
    assign aNeg     = signedOp & a[WIDTH-1];
    assign bNeg     = signedOp & b[WIDTH-1];
    assign aMag     = aNeg ? -a : a;
    assign bMag     = bNeg ? -b : b;

    // Sign-extending to 2*WIDTH makes one multiplier serve both MULT and MULTU.
    assign aExt     = {{WIDTH{aNeg}}, a};
    assign bExt     = {{WIDTH{bNeg}}, b};
    assign fastProd = aExt * bExt;

    // Shift-add: acc = {partial product, remaining multiplier bits}. The low
    // bit of acc picks whether the multiplicand is added into the upper half.
    assign mulSum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? opnd_q : {WIDTH{1'b0}})};
    assign mulNext = {mulSum, acc_q[WIDTH-1:1]};

    // Restoring division: acc = {remainder, dividend bits / quotient bits}.
    // When the trial subtraction fits, the true difference is below the
    // divisor, so the low WIDTH bits of the subtraction are exact.
    assign remShift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    assign divFits  = remShift >= {1'b0, opnd_q};
    assign divNext  = {(divFits ? (remShift[WIDTH-1:0] - opnd_q) : remShift[WIDTH-1:0]),
                       acc_q[WIDTH-2:0], divFits};

    assign lastStep = (step_q == CW'(WIDTH-1));
    assign busy     = (state_q == S_MUL) || (state_q == S_DIV) || (state_q == S_FIX);
    assign accept   = start & ~busy & ~flush;

    // Next-state and result-write logic. DONE behaves like IDLE for accepting
    // a new request so that back-to-back issue works.
    always_comb begin
        state_d = state_q;
        opnd_d  = opnd_q;
        acc_d   = acc_q;
        step_d  = step_q;
        isDiv_d = isDiv_q;
        negLo_d = negLo_q;
        negHi_d = negHi_q;
        dbz_d   = 1'b0;
        hi_d    = hi_q;
        lo_d    = lo_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (accept) begin
                    case (op)
                        OP_MULT, OP_MULTU: begin
                            if (FAST_MUL) begin
                                {hi_d, lo_d} = fastProd;
                                state_d      = S_DONE;
                            end else begin
                                opnd_d  = aMag;
                                acc_d   = {{WIDTH{1'b0}}, bMag};
                                step_d  = '0;
                                isDiv_d = 1'b0;
                                negLo_d = aNeg ^ bNeg;
                                negHi_d = 1'b0;
                                state_d = S_MUL;
                            end
                        end
                        OP_DIV, OP_DIVU: begin
                            if (b == '0) begin
                                hi_d    = a;
                                lo_d    = '1;
                                dbz_d   = 1'b1;
                                state_d = S_DONE;
                            end else begin
                                opnd_d  = bMag;
                                acc_d   = {{WIDTH{1'b0}}, aMag};
                                step_d  = '0;
                                isDiv_d = 1'b1;
                                negLo_d = aNeg ^ bNeg;
                                negHi_d = aNeg;
                                state_d = S_DIV;
                            end
                        end
                        OP_MTHI: begin
                            hi_d    = a;
                            state_d = S_DONE;
                        end
                        OP_MTLO: begin
                            lo_d    = a;
                            state_d = S_DONE;
                        end
                        default: state_d = S_IDLE;
                    endcase
                end
            end
            S_MUL: begin
                acc_d  = mulNext;
                step_d = step_q + CW'(1);
                if (lastStep) state_d = S_FIX;
            end
            S_DIV: begin
                acc_d  = divNext;
                step_d = step_q + CW'(1);
                if (lastStep) state_d = S_FIX;
            end
            S_FIX: begin
                state_d = S_DONE;
                if (isDiv_q) begin
                    lo_d = negLo_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
                    hi_d = negHi_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
                end else begin
                    {hi_d, lo_d} = negLo_q ? -acc_q : acc_q;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Abort wins over the result write that FIX would otherwise perform.
        if (flush && busy) begin
            state_d = S_IDLE;
            hi_d    = hi_q;
            lo_d    = lo_q;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            opnd_q  <= '0;
            acc_q   <= '0;
            step_q  <= '0;
            isDiv_q <= 1'b0;
            negLo_q <= 1'b0;
            negHi_q <= 1'b0;
            dbz_q   <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            opnd_q  <= opnd_d;
            acc_q   <= acc_d;
            step_q  <= step_d;
            isDiv_q <= isDiv_d;
            negLo_q <= negLo_d;
            negHi_q <= negHi_d;
            dbz_q   <= dbz_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign done        = (state_q == S_DONE);
    assign div_by_zero = dbz_q;
    assign hi          = hi_q;
    assign lo          = lo_q;

endmodule

// File: tb/tb_mdu_hilo.sv
// tb_mdu_hilo -- scoreboard bench for mdu_hilo.
// Requests are pushed into a queue with the result and the cycle at which
// done must appear; a monitor pops on every done and also watches busy and
// the hold behaviour of hi/lo between results. A second instance with
// FAST_MUL=1 covers the single-cycle multiply.
module tb_mdu_hilo;

    localparam int W = 32;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        bit          dbz;
        bit          valid;
        bit          iter;
    } res_t;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        bit          dbz;
        bit          iter;
        int          due;
    } sb_t;

    logic        clk, rst;
    logic        start, flush;
    logic [2:0]  op;
    logic [31:0] a, b;
    logic        busy, done, dbz;
    logic [31:0] hi, lo;

    logic        fStart, fFlush;
    logic [2:0]  fOp;
    logic [31:0] fA, fB;
    logic        fBusy, fDone, fDbz;
    logic [31:0] fHi, fLo;

    int          compared   = 0;
    int          mismatched = 0;
    int          cycleCnt   = 0;
    sb_t         sbQ[$];
    sb_t         monE;
    logic        monBusy;
    logic [31:0] hiC = '0;
    logic [31:0] loC = '0;
    logic [31:0] fHiM = '0;
    logic [31:0] fLoM = '0;

    mdu_hilo #(.WIDTH(W), .FAST_MUL(1'b0)) u_dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
        .flush(flush), .busy(busy), .done(done), .div_by_zero(dbz),
        .hi(hi), .lo(lo)
    );

    mdu_hilo #(.WIDTH(W), .FAST_MUL(1'b1)) u_fast (
        .clk(clk), .rst(rst), .start(fStart), .op(fOp), .a(fA), .b(fB),
        .flush(fFlush), .busy(fBusy), .done(fDone), .div_by_zero(fDbz),
        .hi(fHi), .lo(fLo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cycleCnt <= cycleCnt + 1;

    // Reference model straight from the arithmetic definitions, using 64-bit
    // host integers for signed/unsigned products, quotients and remainders.
    function automatic res_t refModel(input logic [2:0] o, input logic [31:0] av,
                                      input logic [31:0] bv, input logic [31:0] curHi,
                                      input logic [31:0] curLo, input bit fast);
        res_t        r;
        longint      sa, sb;
        logic [63:0] p, q, rm;
        r.hi = curHi; r.lo = curLo; r.dbz = 1'b0; r.valid = 1'b1; r.iter = 1'b0;
        sa = longint'($signed(av));
        sb = longint'($signed(bv));
        case (o)
            3'd0: begin p = sa * sb; r.hi = p[63:32]; r.lo = p[31:0]; r.iter = !fast; end
            3'd1: begin p = {32'd0, av} * {32'd0, bv}; r.hi = p[63:32]; r.lo = p[31:0]; r.iter = !fast; end
            3'd2, 3'd3: begin
                if (bv == 32'd0) begin
                    r.hi = av; r.lo = 32'hFFFF_FFFF; r.dbz = 1'b1;
                end else if (o == 3'd2) begin
                    q = sa / sb; rm = sa % sb;
                    r.lo = q[31:0]; r.hi = rm[31:0]; r.iter = 1'b1;
                end else begin
                    r.lo = av / bv; r.hi = av % bv; r.iter = 1'b1;
                end
            end
            3'd4: r.hi = av;
            3'd5: r.lo = av;
            default: r.valid = 1'b0;
        endcase
        return r;
    endfunction

    task automatic checkVal(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cycleCnt);
        end
    endtask

    // Issues one request at the current falling edge; the start edge E0 is
    // the next rising edge. Iterative ops finish WIDTH+1 edges after E0.
    task automatic applyStimulus(input logic [2:0] o, input logic [31:0] av, input logic [31:0] bv);
        res_t r;
        sb_t  e;
        start = 1'b1; op = o; a = av; b = bv;
        r = refModel(o, av, bv, hiC, loC, 1'b0);
        if (r.valid) begin
            e.hi = r.hi; e.lo = r.lo; e.dbz = r.dbz; e.iter = r.iter;
            e.due = cycleCnt + 1 + (r.iter ? W + 1 : 0);
            sbQ.push_back(e);
        end
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic waitDrain();
        for (int k = 0; k < 200 && sbQ.size() != 0; k++) @(negedge clk);
        if (sbQ.size() != 0) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL drain_timeout: %0d results still pending", sbQ.size());
            sbQ.delete();
        end
    endtask

    task automatic checkOutput(input string name, input logic [31:0] expHi, input logic [31:0] expLo);
        checkVal({name, "_hi"}, hi, expHi);
        checkVal({name, "_lo"}, lo, expLo);
    endtask

    task automatic fastMul(input logic [2:0] o, input logic [31:0] av, input logic [31:0] bv);
        res_t r;
        fStart = 1'b1; fOp = o; fA = av; fB = bv;
        r = refModel(o, av, bv, fHiM, fLoM, 1'b1);
        @(posedge clk); #1;
        checkVal("fast_done", fDone, 1'b1);
        checkVal("fast_busy", fBusy, 1'b0);
        checkVal("fast_dbz", fDbz, 1'b0);
        checkVal("fast_hi", fHi, r.hi);
        checkVal("fast_lo", fLo, r.lo);
        fHiM = r.hi; fLoM = r.lo;
        @(negedge clk);
        fStart = 1'b0;
        @(posedge clk); #1;
        checkVal("fast_done_pulse", fDone, 1'b0);
        @(negedge clk);
    endtask

    // Monitor: pops the scoreboard on done, checks latency and values, and
    // between results checks that busy, hi and lo behave as expected.
    always @(posedge clk) begin
        #1;
        if (!rst) begin
            monBusy = (sbQ.size() > 0) && sbQ[0].iter && (cycleCnt < sbQ[0].due);
            checkVal("busy", busy, monBusy);
            if (done) begin
                if (sbQ.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("[TB] FAIL unexpected_done: done=1 with no request pending (cycle %0d)", cycleCnt);
                end else begin
                    monE = sbQ.pop_front();
                    checkVal("done_cycle", cycleCnt, monE.due);
                    checkVal("result_hi", hi, monE.hi);
                    checkVal("result_lo", lo, monE.lo);
                    checkVal("div_by_zero", dbz, monE.dbz);
                    hiC = monE.hi;
                    loC = monE.lo;
                end
            end else begin
                checkVal("dbz_idle", dbz, 1'b0);
                checkVal("hi_hold", hi, hiC);
                checkVal("lo_hold", lo, loC);
                if (sbQ.size() > 0 && cycleCnt >= sbQ[0].due) begin
                    compared++;
                    mismatched++;
                    $display("[TB] FAIL missing_done: got no done, expected one at cycle %0d", sbQ[0].due);
                    void'(sbQ.pop_front());
                end
            end
        end
    end

    initial begin
        logic [2:0]  o;
        logic [31:0] av, bv;
        bit          inFlight;

        rst = 1'b1; start = 1'b0; flush = 1'b0; op = '0; a = '0; b = '0;
        fStart = 1'b0; fFlush = 1'b0; fOp = '0; fA = '0; fB = '0;
        repeat (2) @(negedge clk);
        checkVal("reset_hi", hi, 32'd0);
        checkVal("reset_lo", lo, 32'd0);
        checkVal("reset_busy", busy, 1'b0);
        checkVal("reset_done", done, 1'b0);
        checkVal("reset_dbz", dbz, 1'b0);
        rst = 1'b0;
        @(negedge clk);

        applyStimulus(3'd0, 32'hFFFF_FFFD, 32'd7);
        waitDrain();
        checkOutput("mult_neg", 32'hFFFF_FFFF, 32'hFFFF_FFEB);

        applyStimulus(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        waitDrain();
        checkOutput("multu_max", 32'hFFFF_FFFE, 32'h0000_0001);

        applyStimulus(3'd2, 32'hFFFF_FFF9, 32'd2);
        waitDrain();
        checkOutput("div_neg", 32'hFFFF_FFFF, 32'hFFFF_FFFD);

        applyStimulus(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
        waitDrain();
        checkOutput("div_min", 32'h0000_0000, 32'h8000_0000);

        applyStimulus(3'd3, 32'h0000_002A, 32'd0);
        waitDrain();
        checkOutput("divu_zero", 32'h0000_002A, 32'hFFFF_FFFF);

        // MULTU 5*6: a second start while busy is dropped, then a flush at
        // E0+10 discards the op entirely.
        applyStimulus(3'd1, 32'd5, 32'd6);
        start = 1'b1; op = 3'd4; a = 32'hDEAD_BEEF; b = 32'd1;
        @(negedge clk);
        start = 1'b0;
        repeat (8) @(negedge clk);
        flush = 1'b1;
        sbQ.delete();
        @(negedge clk);
        flush = 1'b0;
        repeat (40) @(negedge clk);
        checkOutput("flush_keep", 32'h0000_002A, 32'hFFFF_FFFF);

        applyStimulus(3'd4, 32'h1234_5678, 32'd0);
        applyStimulus(3'd5, 32'h9ABC_DEF0, 32'd0);
        waitDrain();
        checkOutput("mthi_mtlo", 32'h1234_5678, 32'h9ABC_DEF0);

        fastMul(3'd0, 32'd3, 32'd4);
        fastMul(3'd0, 32'hFFFF_FFF0, 32'd9);
        for (int i = 0; i < 6; i++) fastMul(3'($urandom_range(0, 1)), $urandom, $urandom);

        for (int i = 0; i < 50; i++) begin
            o  = 3'($urandom_range(0, 7));
            av = $urandom;
            bv = $urandom;
            case ($urandom_range(0, 7))
                0: bv = 32'd0;
                1: bv = 32'hFFFF_FFFF;
                2: bv = 32'($urandom_range(1, 9));
                3: av = 32'h8000_0000;
                default: ;
            endcase
            applyStimulus(o, av, bv);
            inFlight = (sbQ.size() > 0) && sbQ[0].iter;
            if (inFlight && $urandom_range(0, 3) == 0) begin
                start = 1'b1; op = 3'($urandom_range(0, 5)); a = $urandom; b = $urandom;
                @(negedge clk);
                start = 1'b0;
            end
            if (inFlight && $urandom_range(0, 5) == 0) begin
                repeat ($urandom_range(0, 28)) @(negedge clk);
                flush = 1'b1;
                sbQ.delete();
                @(negedge clk);
                flush = 1'b0;
            end
            waitDrain();
            if ($urandom_range(0, 1) == 0) @(negedge clk);
        end

        // Reset in the middle of a divide clears everything.
        applyStimulus(3'd2, 32'd1000, 32'd7);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        sbQ.delete();
        hiC = '0;
        loC = '0;
        #1;
        checkVal("rst_mid_hi", hi, 32'd0);
        checkVal("rst_mid_lo", lo, 32'd0);
        checkVal("rst_mid_busy", busy, 1'b0);
        checkVal("rst_mid_done", done, 1'b0);
        checkVal("rst_mid_dbz", dbz, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        applyStimulus(3'd1, 32'd5, 32'd6);
        waitDrain();
        checkOutput("after_reset", 32'd0, 32'd30);

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
